// File: rtl/msrh_l2_arbiter_if.sv
// Bus bundle between the tile's L2 requesters, msrh_l2_arbiter and the L2 port.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface msrh_l2_arbiter_if #(
    parameter int unsigned REQ_PORTS       = 2,
    parameter int unsigned PADDR_W         = 56,
    parameter int unsigned LINE_W          = 512,
    parameter int unsigned TAG_W           = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
);
    localparam int unsigned SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [REQ_PORTS-1:0]         i_req_valid;
    logic [REQ_PORTS-1:0]         o_req_ready;
    logic [REQ_PORTS-1:0]         i_req_cmd;
    logic [REQ_PORTS*PADDR_W-1:0] i_req_addr;
    logic [REQ_PORTS*TAG_W-1:0]   i_req_tag;
    logic [REQ_PORTS*LINE_W-1:0]  i_req_data;
    logic [REQ_PORTS-1:0]         o_resp_valid;
    logic [REQ_PORTS-1:0]         i_resp_ready;
    logic [TAG_W-1:0]             o_resp_tag;
    logic [LINE_W-1:0]            o_resp_data;
    logic                         o_l2_req_valid;
    logic                         i_l2_req_ready;
    logic                         o_l2_req_cmd;
    logic [PADDR_W-1:0]           o_l2_req_addr;
    logic [SLOT_W-1:0]            o_l2_req_tag;
    logic [LINE_W-1:0]            o_l2_req_data;
    logic                         i_l2_resp_valid;
    logic                         o_l2_resp_ready;
    logic [SLOT_W-1:0]            i_l2_resp_tag;
    logic [LINE_W-1:0]            i_l2_resp_data;

    modport slave (
        input  i_req_valid, i_req_cmd, i_req_addr, i_req_tag, i_req_data, i_resp_ready,
        input  i_l2_req_ready, i_l2_resp_valid, i_l2_resp_tag, i_l2_resp_data,
        output o_req_ready, o_resp_valid, o_resp_tag, o_resp_data,
        output o_l2_req_valid, o_l2_req_cmd, o_l2_req_addr, o_l2_req_tag, o_l2_req_data,
        output o_l2_resp_ready
    );

    modport master (
        output i_req_valid, i_req_cmd, i_req_addr, i_req_tag, i_req_data, i_resp_ready,
        output i_l2_req_ready, i_l2_resp_valid, i_l2_resp_tag, i_l2_resp_data,
        input  o_req_ready, o_resp_valid, o_resp_tag, o_resp_data,
        input  o_l2_req_valid, o_l2_req_cmd, o_l2_req_addr, o_l2_req_tag, o_l2_req_data,
        input  o_l2_resp_ready
    );
endinterface

// File: rtl/msrh_l2_arbiter.sv
// Round-robin arbiter of REQ_PORTS L2 requesters onto one L2 channel, with a slot table that
// routes out-of-order responses home. Define MSRH_L2_ARB_PERF_EN for per-port perf counters.
module msrh_l2_arbiter #(
    parameter int unsigned REQ_PORTS       = 2,
    parameter int unsigned PADDR_W         = 56,
    parameter int unsigned LINE_W          = 512,
    parameter int unsigned TAG_W           = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    msrh_l2_arbiter_if.slave        bus,
    output logic                    o_err
`ifdef MSRH_L2_ARB_PERF_EN
    ,
    output logic [REQ_PORTS*32-1:0] o_perf_grant_cnt,
    output logic [REQ_PORTS*32-1:0] o_perf_stall_cnt
`endif
);
    localparam int unsigned SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned PORT_W = (REQ_PORTS > 1) ? $clog2(REQ_PORTS) : 1;

    logic [PORT_W-1:0]          rr_ptr;
    logic [MAX_OUTSTANDING-1:0] slot_vld;
    logic [PORT_W-1:0]          slot_port [MAX_OUTSTANDING];
    logic [TAG_W-1:0]           slot_tag  [MAX_OUTSTANDING];

    logic                       out_vld;
    logic                       out_cmd;
    logic [PADDR_W-1:0]         out_addr;
    logic [SLOT_W-1:0]          out_slot;
    logic [LINE_W-1:0]          out_data;

    logic                       win_found;
    logic [PORT_W-1:0]          win_idx;
    logic [PORT_W-1:0]          next_ptr;
    logic                       sel_cmd;
    logic [PADDR_W-1:0]         sel_addr;
    logic [TAG_W-1:0]           sel_tag;
    logic [LINE_W-1:0]          sel_data;
    int unsigned                cand;

    logic                       free_found;
    logic [SLOT_W-1:0]          free_idx;
    logic                       out_free;
    logic                       grant;

    logic                       slot_hit;
    logic                       resp_hit;
    logic                       resp_fire;
    logic [PORT_W-1:0]          resp_port;
    logic [TAG_W-1:0]           resp_tag;

    // Round-robin search starting at rr_ptr, wrapping modulo REQ_PORTS.
    always_comb begin : rr_pick
        win_found = 1'b0;
        win_idx   = '0;
        sel_cmd   = 1'b0;
        sel_addr  = '0;
        sel_tag   = '0;
        sel_data  = '0;
        cand      = 0;
        for (int unsigned i = 0; i < REQ_PORTS; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= REQ_PORTS) begin
                cand = cand - REQ_PORTS;
            end
            if (!win_found && bus.i_req_valid[PORT_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PORT_W'(cand);
                sel_cmd   = bus.i_req_cmd[PORT_W'(cand)];
                sel_addr  = bus.i_req_addr[cand*PADDR_W +: PADDR_W];
                sel_tag   = bus.i_req_tag[cand*TAG_W +: TAG_W];
                sel_data  = bus.i_req_data[cand*LINE_W +: LINE_W];
            end
        end
    end

    assign next_ptr = (win_idx == PORT_W'(REQ_PORTS - 1)) ? '0 : win_idx + PORT_W'(1);

    // Lowest free slot, judged on table state at the start of the cycle.
    always_comb begin : free_pick
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned s = 0; s < MAX_OUTSTANDING; s++) begin
            if (!free_found && !slot_vld[s]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(s);
            end
        end
    end

    assign out_free = !out_vld || bus.i_l2_req_ready;
    assign grant    = out_free && free_found && win_found;

    always_comb begin : ready_gen
        bus.o_req_ready = '0;
        if (grant) begin
            bus.o_req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin : resp_lookup
        slot_hit  = 1'b0;
        resp_port = '0;
        resp_tag  = '0;
        for (int unsigned s = 0; s < MAX_OUTSTANDING; s++) begin
            if (SLOT_W'(s) == bus.i_l2_resp_tag && slot_vld[s]) begin
                slot_hit  = 1'b1;
                resp_port = slot_port[s];
                resp_tag  = slot_tag[s];
            end
        end
    end

    assign resp_hit  = bus.i_l2_resp_valid && slot_hit;
    assign resp_fire = resp_hit && bus.i_resp_ready[resp_port];

    // Responses to an empty slot are accepted and dropped so the L2 never stalls on them.
    always_comb begin : resp_route
        bus.o_resp_valid    = '0;
        bus.o_resp_tag      = '0;
        bus.o_resp_data     = '0;
        bus.o_l2_resp_ready = 1'b0;
        if (resp_hit) begin
            bus.o_resp_valid[resp_port] = 1'b1;
            bus.o_resp_tag              = resp_tag;
            bus.o_resp_data             = bus.i_l2_resp_data;
            bus.o_l2_resp_ready         = bus.i_resp_ready[resp_port];
        end else if (bus.i_l2_resp_valid) begin
            bus.o_l2_resp_ready = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin : state_q
        if (!i_reset_n) begin
            rr_ptr   <= '0;
            slot_vld <= '0;
            out_vld  <= 1'b0;
            out_cmd  <= 1'b0;
            out_addr <= '0;
            out_slot <= '0;
            out_data <= '0;
            o_err    <= 1'b0;
            for (int unsigned s = 0; s < MAX_OUTSTANDING; s++) begin
                slot_port[s] <= '0;
                slot_tag[s]  <= '0;
            end
        end else begin
            if (resp_fire) begin
                slot_vld[bus.i_l2_resp_tag] <= 1'b0;
            end
            if (bus.i_l2_resp_valid && !slot_hit) begin
                o_err <= 1'b1;
            end
            // A freed slot is never the allocated one in the same cycle, so both updates coexist.
            if (grant) begin
                rr_ptr              <= next_ptr;
                slot_vld[free_idx]  <= 1'b1;
                slot_port[free_idx] <= win_idx;
                slot_tag[free_idx]  <= sel_tag;
                out_vld             <= 1'b1;
                out_cmd             <= sel_cmd;
                out_addr            <= sel_addr;
                out_slot            <= free_idx;
                out_data            <= sel_data;
            end else if (bus.i_l2_req_ready) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign bus.o_l2_req_valid = out_vld;
    assign bus.o_l2_req_cmd   = out_cmd;
    assign bus.o_l2_req_addr  = out_addr;
    assign bus.o_l2_req_tag   = out_slot;
    assign bus.o_l2_req_data  = out_data;

`ifdef MSRH_L2_ARB_PERF_EN
    // Per-port handshake and stall counters, free-running with natural 32-bit wrap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin : perf_q
        if (!i_reset_n) begin
            o_perf_grant_cnt <= '0;
            o_perf_stall_cnt <= '0;
        end else begin
            for (int unsigned p = 0; p < REQ_PORTS; p++) begin
                if (bus.i_req_valid[p] && bus.o_req_ready[p]) begin
                    o_perf_grant_cnt[p*32 +: 32] <= o_perf_grant_cnt[p*32 +: 32] + 32'd1;
                end
                if (bus.i_req_valid[p] && !bus.o_req_ready[p]) begin
                    o_perf_stall_cnt[p*32 +: 32] <= o_perf_stall_cnt[p*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_msrh_l2_arbiter.sv
// Directed bench for msrh_l2_arbiter: expected L2 requests and upstream responses are queued by
// the stimulus and popped by a monitor on every handshake; cycle-level behaviour is checked inline.
module tb_msrh_l2_arbiter;
    localparam int unsigned REQ_PORTS       = 2;
    localparam int unsigned PADDR_W         = 56;
    localparam int unsigned LINE_W          = 512;
    localparam int unsigned TAG_W           = 8;
    localparam int unsigned MAX_OUTSTANDING = 4;
    localparam int unsigned SLOT_W          = 2;

    typedef struct {
        logic               cmd;
        logic [PADDR_W-1:0] addr;
        logic [SLOT_W-1:0]  slot;
        logic [LINE_W-1:0]  data;
    } l2_exp_t;

    typedef struct {
        int unsigned        port;
        logic [TAG_W-1:0]   tag;
        logic [LINE_W-1:0]  data;
    } resp_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    int   errors = 0;
    int   checks = 0;

    l2_exp_t   l2_q[$];
    resp_exp_t resp_q[$];

    // Round-robin grant order 0,1,0,1 into slots 0..3: port0 reads, port1 writes.
    logic               t2_cmd   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [PADDR_W-1:0] t2_addr  [4] = '{56'h2000, 56'h3000, 56'h2040, 56'h3040};
    logic [7:0]         t2_dbyte [4] = '{8'h00, 8'h31, 8'h00, 8'h32};

    msrh_l2_arbiter_if #(
        .REQ_PORTS(REQ_PORTS), .PADDR_W(PADDR_W), .LINE_W(LINE_W),
        .TAG_W(TAG_W), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) bus ();

`ifdef MSRH_L2_ARB_PERF_EN
    logic [REQ_PORTS*32-1:0] perf_grant;
    logic [REQ_PORTS*32-1:0] perf_stall;
`endif

    msrh_l2_arbiter #(
        .REQ_PORTS(REQ_PORTS), .PADDR_W(PADDR_W), .LINE_W(LINE_W),
        .TAG_W(TAG_W), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus),
        .o_err     (err)
`ifdef MSRH_L2_ARB_PERF_EN
        ,
        .o_perf_grant_cnt (perf_grant),
        .o_perf_stall_cnt (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] mk(input logic [7:0] b);
        return {(LINE_W/8){b}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_line(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int unsigned p, input logic cmd, input logic [PADDR_W-1:0] addr,
                           input logic [TAG_W-1:0] tag, input logic [LINE_W-1:0] data);
        bus.i_req_cmd[p]                     = cmd;
        bus.i_req_addr[p*PADDR_W +: PADDR_W] = addr;
        bus.i_req_tag[p*TAG_W +: TAG_W]      = tag;
        bus.i_req_data[p*LINE_W +: LINE_W]   = data;
    endtask

    // Request number j of a port in the alternation test.
    task automatic drive_port(input int unsigned p, input int unsigned j);
        if (p == 0) begin
            set_req(0, 1'b0, PADDR_W'(32'h2000 + 32'h40 * j), TAG_W'(32'h10 + j), mk(8'h00));
        end else begin
            set_req(1, 1'b1, PADDR_W'(32'h3000 + 32'h40 * j), TAG_W'(32'h20 + j), mk(8'(32'h31 + j)));
        end
    endtask

    task automatic l2_resp(input logic [SLOT_W-1:0] slot, input logic [7:0] b);
        bus.i_l2_resp_valid = 1'b1;
        bus.i_l2_resp_tag   = slot;
        bus.i_l2_resp_data  = mk(b);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.i_req_valid     = '0;
        bus.i_l2_resp_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic monitor();
        l2_exp_t     le;
        resp_exp_t   re;
        logic [REQ_PORTS-1:0] fire;
        forever begin
            @(negedge clk);
            if (bus.o_l2_req_valid && bus.i_l2_req_ready) begin
                if (l2_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL l2_req_unexpected: got addr %0h expected none", bus.o_l2_req_addr);
                end else begin
                    le = l2_q.pop_front();
                    chk("l2_req_cmd", 64'(bus.o_l2_req_cmd), 64'(le.cmd));
                    chk("l2_req_addr", 64'(bus.o_l2_req_addr), 64'(le.addr));
                    chk("l2_req_tag", 64'(bus.o_l2_req_tag), 64'(le.slot));
                    chk_line("l2_req_data", bus.o_l2_req_data, le.data);
                end
            end
            fire = bus.o_resp_valid & bus.i_resp_ready;
            if (fire != '0) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got valid %0h tag %0h expected none", bus.o_resp_valid, bus.o_resp_tag);
                end else begin
                    re = resp_q.pop_front();
                    chk("resp_port", 64'(bus.o_resp_valid), 64'(1) << re.port);
                    chk("resp_tag", 64'(bus.o_resp_tag), 64'(re.tag));
                    chk_line("resp_data", bus.o_resp_data, re.data);
                end
            end
        end
    endtask

    initial begin
        bus.i_req_valid     = '0;
        bus.i_req_cmd       = '0;
        bus.i_req_addr      = '0;
        bus.i_req_tag       = '0;
        bus.i_req_data      = '0;
        bus.i_resp_ready    = '1;
        bus.i_l2_req_ready  = 1'b1;
        bus.i_l2_resp_valid = 1'b0;
        bus.i_l2_resp_tag   = '0;
        bus.i_l2_resp_data  = '0;
        fork
            monitor();
        join_none

        // Reset state
        @(negedge clk);
        chk("rst_l2_valid", 64'(bus.o_l2_req_valid), 64'h0);
        chk("rst_req_ready", 64'(bus.o_req_ready), 64'h0);
        chk("rst_resp_valid", 64'(bus.o_resp_valid), 64'h0);
        chk("rst_l2_resp_ready", 64'(bus.o_l2_resp_ready), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Single read: one-cycle request latency, then a response restores tag 0x05
        set_req(0, 1'b0, 56'h1000, 8'h05, mk(8'h00));
        bus.i_req_valid = 2'b01;
        l2_q.push_back('{1'b0, 56'h1000, 2'd0, mk(8'h00)});
        @(negedge clk);
        chk("t1_ready", 64'(bus.o_req_ready), 64'h1);
        chk("t1_l2_valid_n", 64'(bus.o_l2_req_valid), 64'h0);
        next_cycle();
        bus.i_req_valid = '0;
        @(negedge clk);
        chk("t1_l2_valid_n1", 64'(bus.o_l2_req_valid), 64'h1);
        next_cycle();
        l2_resp(2'd0, 8'hAA);
        resp_q.push_back('{0, 8'h05, mk(8'hAA)});
        @(negedge clk);
        chk("t1_l2_resp_ready", 64'(bus.o_l2_resp_ready), 64'h1);
        next_cycle();
        bus.i_l2_resp_valid = 1'b0;

        // Both ports always valid from pointer 0: grants 0,1,0,1 into slots 0..3
        do_reset();
        drive_port(0, 0);
        drive_port(1, 0);
        bus.i_req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            l2_q.push_back('{t2_cmd[k], t2_addr[k], SLOT_W'(k), mk(t2_dbyte[k])});
            @(negedge clk);
            chk("t2_rr_ready", 64'(bus.o_req_ready), 64'(1) << (k % 2));
            next_cycle();
            drive_port(32'(k % 2), 32'(k / 2 + 1));
        end

        // Table full: no grant for several cycles while the last request drains
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_full_ready", 64'(bus.o_req_ready), 64'h0);
            next_cycle();
        end
        l2_resp(2'd2, 8'hC2);
        resp_q.push_back('{0, 8'h11, mk(8'hC2)});
        @(negedge clk);
        chk("t3_free_same_cycle", 64'(bus.o_req_ready), 64'h0);
        next_cycle();
        bus.i_l2_resp_valid = 1'b0;
        l2_q.push_back('{1'b0, 56'h2080, 2'd2, mk(8'h00)});
        @(negedge clk);
        chk("t3_reuse_ready", 64'(bus.o_req_ready), 64'h1);
        next_cycle();
        bus.i_req_valid = 2'b10;
        @(negedge clk);
        chk("t3_full_again", 64'(bus.o_req_ready), 64'h0);
        next_cycle();
        bus.i_req_valid = '0;

        // Out-of-order responses: slot 3 (port1 0x21) then slot 0 (port0 0x10)
        l2_resp(2'd3, 8'hD3);
        resp_q.push_back('{1, 8'h21, mk(8'hD3)});
        @(negedge clk);
        chk("t4_resp_valid", 64'(bus.o_resp_valid), 64'h2);
        next_cycle();
        l2_resp(2'd0, 8'hD0);
        resp_q.push_back('{0, 8'h10, mk(8'hD0)});
        next_cycle();
        bus.i_l2_resp_valid = 1'b0;

        // Upstream backpressure on port1 holds slot 1 until the handshake
        bus.i_resp_ready = 2'b01;
        l2_resp(2'd1, 8'hB1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_bp_resp_valid", 64'(bus.o_resp_valid), 64'h2);
            chk("t5_bp_l2_ready", 64'(bus.o_l2_resp_ready), 64'h0);
            chk("t5_bp_tag", 64'(bus.o_resp_tag), 64'h20);
            next_cycle();
        end
        bus.i_resp_ready = 2'b11;
        resp_q.push_back('{1, 8'h20, mk(8'hB1)});
        @(negedge clk);
        chk("t5_release_l2_ready", 64'(bus.o_l2_resp_ready), 64'h1);
        next_cycle();
        bus.i_l2_resp_valid = 1'b0;

        // Same-cycle grant (port1 into slot 0) and response freeing slot 2
        set_req(1, 1'b0, 56'h4000, 8'h33, mk(8'h00));
        bus.i_req_valid = 2'b10;
        l2_q.push_back('{1'b0, 56'h4000, 2'd0, mk(8'h00)});
        l2_resp(2'd2, 8'hE2);
        resp_q.push_back('{0, 8'h12, mk(8'hE2)});
        @(negedge clk);
        chk("t5b_grant_ready", 64'(bus.o_req_ready), 64'h2);
        next_cycle();
        bus.i_req_valid = '0;
        l2_resp(2'd0, 8'hE0);
        resp_q.push_back('{1, 8'h33, mk(8'hE0)});
        next_cycle();
        bus.i_l2_resp_valid = 1'b0;

        // Response to an empty slot: dropped, sticky error
        l2_resp(2'd1, 8'h66);
        @(negedge clk);
        chk("t6_drop_resp_valid", 64'(bus.o_resp_valid), 64'h0);
        chk("t6_drop_l2_ready", 64'(bus.o_l2_resp_ready), 64'h1);
        chk("t6_err_before", 64'(err), 64'h0);
        next_cycle();
        bus.i_l2_resp_valid = 1'b0;
        @(negedge clk);
        chk("t6_err_set", 64'(err), 64'h1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("t6_err_sticky", 64'(err), 64'h1);
        next_cycle();

        // Output register holds under L2 backpressure, then async reset mid-transaction
        bus.i_l2_req_ready = 1'b0;
        set_req(0, 1'b1, 56'h5000, 8'h44, mk(8'h55));
        bus.i_req_valid = 2'b01;
        @(negedge clk);
        chk("t7_ready", 64'(bus.o_req_ready), 64'h1);
        next_cycle();
        set_req(1, 1'b0, 56'h6000, 8'h45, mk(8'h00));
        bus.i_req_valid = 2'b10;
        @(negedge clk);
        chk("t7_hold_valid", 64'(bus.o_l2_req_valid), 64'h1);
        chk("t7_hold_addr", 64'(bus.o_l2_req_addr), 64'h5000);
        chk("t7_blocked_ready", 64'(bus.o_req_ready), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("t7_hold_addr2", 64'(bus.o_l2_req_addr), 64'h5000);
        chk_line("t7_hold_data", bus.o_l2_req_data, mk(8'h55));
        next_cycle();
        bus.i_req_valid = '0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t7_rst_l2_valid", 64'(bus.o_l2_req_valid), 64'h0);
        chk("t7_rst_err", 64'(err), 64'h0);
        chk("t7_rst_ready", 64'(bus.o_req_ready), 64'h0);
        chk("t7_rst_resp_valid", 64'(bus.o_resp_valid), 64'h0);
        next_cycle();
        rst_n = 1'b1;
        bus.i_l2_req_ready = 1'b1;
        l2_resp(2'd0, 8'h77);
        @(negedge clk);
        chk("t7_table_empty", 64'(bus.o_resp_valid), 64'h0);
        chk("t7_drop_after_rst", 64'(bus.o_l2_resp_ready), 64'h1);
        chk("t7_l2_idle", 64'(bus.o_l2_req_valid), 64'h0);
        next_cycle();
        bus.i_l2_resp_valid = 1'b0;
        @(negedge clk);
        chk("t7_err_after_rst", 64'(err), 64'h1);

        next_cycle();
        chk("l2_queue_drained", 64'(l2_q.size()), 64'h0);
        chk("resp_queue_drained", 64'(resp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/msrh_l2_arbiter.md
Name: msrh_l2_arbiter

Overview:
Sits directly upstream of msrh_tile's L2 ports and downstream of every L2 requester in the tile: today the ICache port, later DCache and PTW ports. Arbitrates REQ_PORTS requesters round-robin onto a single L2 request channel. Tracks outstanding transactions in a slot table and routes out-of-order L2 responses back to the originating port with the original tag restored.

Parameters:
REQ_PORTS, 2, number of upstream requesters
PADDR_W, 56, physical address width
LINE_W, 512, request/response data width (one cache line)
TAG_W, 8, upstream tag width
MAX_OUTSTANDING, 4, slot-table depth; downstream tag width SLOT_W = $clog2(MAX_OUTSTANDING)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_req_valid  in  REQ_PORTS  per-port request valid
o_req_ready  out  REQ_PORTS  per-port grant; handshake = valid & ready
i_req_cmd  in  REQ_PORTS  per-port command: 0 = read, 1 = write
i_req_addr  in  REQ_PORTS*PADDR_W  per-port address, port p at slice p
i_req_tag  in  REQ_PORTS*TAG_W  per-port tag
i_req_data  in  REQ_PORTS*LINE_W  per-port write data
o_resp_valid  out  REQ_PORTS  per-port response valid
i_resp_ready  in  REQ_PORTS  per-port response ready
o_resp_tag  out  TAG_W  restored upstream tag, shared bus
o_resp_data  out  LINE_W  response data, shared bus
o_l2_req_valid  out  1  downstream request valid
i_l2_req_ready  in  1  downstream request ready
o_l2_req_cmd  out  1  downstream command
o_l2_req_addr  out  PADDR_W  downstream address
o_l2_req_tag  out  SLOT_W  slot index
o_l2_req_data  out  LINE_W  downstream write data
i_l2_resp_valid  in  1  downstream response valid
o_l2_resp_ready  out  1  downstream response ready
i_l2_resp_tag  in  SLOT_W  slot index of the response
i_l2_resp_data  in  LINE_W  response data
o_err  out  1  sticky error: response to an invalid slot

Behaviour:
- Reset (async, i_reset_n=0):
  - all outputs 0
  - slot table cleared
  - output register empty
  - RR pointer = 0
  - o_err = 0
  - in-flight transactions are discarded, no responses issued
- Output register (one entry) drives o_l2_req_*. Emptied on o_l2_req_valid & i_l2_req_ready.
- Grant condition for cycle N:
  - the output register is empty, or is being emptied in cycle N
  - at least one slot is free, judged on table state at the start of cycle N (a slot freed in cycle N is not reusable until N+1)
  - at least one i_req_valid is set
- Round-robin:
  - search starts at pointer, wraps modulo REQ_PORTS
  - first valid port wins; exactly one o_req_ready bit is set
  - after a grant, pointer = winner+1 (wrapping); no grant leaves the pointer unchanged
- o_req_ready is combinational from valids and state. A port may see ready only while its valid is high.
- On grant:
  - allocate the lowest-index free slot and store {valid, port, tag}
  - load the output register with cmd/addr/data and o_l2_req_tag = slot
  - o_l2_req_valid rises at N+1 (one-cycle request latency)
- The output register holds stable while valid & !ready.
- Every command, read and write, receives exactly one response.
- Response path (combinational, zero latency):
  - on i_l2_resp_valid, look up slot i_l2_resp_tag
  - if the slot is valid: o_resp_valid[port]=1, o_resp_tag = stored tag, o_resp_data = i_l2_resp_data, o_l2_resp_ready = i_resp_ready[port]
  - on handshake the slot is freed at the clock edge
- Invalid slot: o_l2_resp_ready=1 (drop), no o_resp_valid, o_err set until reset.
- Full table (MAX_OUTSTANDING slots valid): no grants; the output register still drains.
- Same-cycle grant and response on different slots is legal and both take effect.

Optional Feature:
MSRH_L2_ARB_PERF_EN:
- When defined, adds output o_perf_grant_cnt (REQ_PORTS*32) and o_perf_stall_cnt (REQ_PORTS*32).
- Per port, grant counts handshakes and stall counts cycles with valid & !ready.
- Counters reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist.

Test Plan:
- Port0 read addr 0x1000 tag 0x05, L2 ready -> o_l2_req_valid at N+1 with tag 0; L2 response tag 0 data 0xAA.. -> o_resp_valid[0], o_resp_tag 0x05.
- Both ports valid every cycle, L2 always ready, pointer starts 0 -> grants alternate 0,1,0,1; slots 0,1,2,3 allocated.
- Four reads outstanding, no responses -> o_req_ready stays 0; one response on slot 2 -> next cycle a grant reuses slot 2.
- Responses on slots 3,0 (port1 tag 0x7, port0 tag 0x9) out of order -> routed to port1/0x7, then port0/0x9.
- i_resp_ready[1]=0 for 3 cycles during its response -> o_l2_resp_ready=0 and the slot is held; the slot frees on the handshake.
- Response with tag 1 to an empty table -> dropped, o_err=1; reset mid-transaction -> all outputs 0, table empty, o_err=0.
